reg_bank: RTL and testbench
===========================

# reg_bank

Parametrised register bank with two registered read ports, one write port, per-register busy scoreboard and optional write-to-read bypass. Replaces the fixed 64×32 register file in the datapath. It feeds operand values and hazard status to the execute stage and takes writeback from the final stage. Everything runs on one clock edge, so write and read happen on the same rising edge.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 64, number of registers (≥2); address width AW = $clog2(DEPTH), derived locally
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes and reservations
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- rs_a  input  AW  read port A address
- rt_a  input  AW  read port B address
- rs  output  WIDTH  read port A data, registered
- rt  output  WIDTH  read port B data, registered
- rd_a  input  AW  write address
- rd  input  WIDTH  write data
- write  input  1  write enable
- rsv  input  1  reserve enable: marks rsv_a as having a result in flight
- rsv_a  input  AW  reserve address
- rs_busy  output  1  busy bit of rs_a, registered alongside rs
- rt_busy  output  1  busy bit of rt_a, registered alongside rt
- hazard  output  1  rs_busy | rt_busy, combinational from those two flops

## Operation
- Storage: DEPTH×WIDTH array plus DEPTH busy bits.
- Reset (rst_n=0, asynchronous): all registers 0, all busy bits 0, rs=rt=0, rs_busy=rt_busy=0, hazard=0. This holds while rst_n is low. The first update happens on the first rising edge after rst_n goes high.
- Write: on a rising edge with write=1, regs[rd_a]←rd. The write is dropped if ZERO_REG=1 and rd_a=0, or if rd_a≥DEPTH.
- Write clears busy: an accepted write clears busy[rd_a].
- Reserve: on a rising edge with rsv=1, busy[rsv_a]←1. Ignored if ZERO_REG=1 and rsv_a=0, or if rsv_a≥DEPTH.
- Simultaneous write and reserve to the same address: the data is written and busy ends at 1, because the reserve wins as the newer producer.
- Reserve of an address that is already busy: it stays 1. There is no counting; one write clears it.
- Read: on every rising edge, rs←regs[rs_a] and rt←regs[rt_a]. rs_busy and rt_busy sample busy[rs_a] and busy[rt_a] on the same edge.
- ZERO_REG=1 and address 0: rs or rt = 0, busy output = 0.
- Read address ≥DEPTH: data 0, busy 0.
- rs_a = rt_a is legal; both ports return the same value.

## Timing
- Read latency is 1 cycle: the address presented before edge N appears on rs/rt after edge N.
- Write latency is 1 cycle: data written at edge N is in the array after edge N.
- Same-edge read and write to the same address:
  - Without bypass, the read returns the old array value and the old busy bit.
  - With bypass, the read returns rd and the post-update busy bit (see Configuration).
- Busy set by rsv at edge N is visible on rs_busy/rt_busy from edge N+1 without bypass, or from edge N with bypass.
- No handshake and no back-pressure. The bank never stalls; the pipeline consumes hazard.
- Reset asserted mid-operation discards any in-flight write or reserve on that edge.

## Configuration
- REG_BANK_BYPASS_EN defined:
  - A read port whose address equals an accepted same-edge write address returns rd instead of the array value.
  - rs_busy/rt_busy return the busy state after that edge's write-clear and reserve-set are applied.
  - Reserve wins over the clear, as in Operation.
- Undefined: reads return pre-edge array contents and pre-edge busy bits. There is no forwarding logic.

## Test plan
- Reset: drive rst_n=0 mid-cycle with regs loaded → rs, rt, busy outputs and hazard go to 0 immediately. After release, a read of address 5 returns 0.
- Basic write/read: write 0xDEADBEEF to reg 7, then read rs_a=7, rt_a=7 on the next edge → both ports show 0xDEADBEEF one cycle later.
- Zero register (ZERO_REG=1): write 0x1234 to reg 0 and reserve reg 0 → rs=0, rs_busy=0, hazard=0.
- Scoreboard: reserve reg 3, then read rs_a=3 → rs_busy=1, hazard=1. Write 0x55 to reg 3 → the next read shows rs=0x55, rs_busy=0. Reserve and write reg 3 on the same edge → busy stays 1.
- Same-edge read-after-write to reg 9, old value 0x11, new value 0x22:
  - With REG_BANK_BYPASS_EN: rs=0x22.
  - Without it: rs=0x11, and the following cycle rs=0x22.
- Parameter sweep with WIDTH=16, DEPTH=12: write 0xABCD to reg 11 and read it back correctly. A write to address 13 is ignored, and a read of address 13 returns 0.

Source files
------------

// File: rtl/reg_bank.sv
// reg_bank: parameterised register bank, two registered read ports, one write port, busy scoreboard.
// Optional same-edge write-to-read forwarding is enabled by defining REG_BANK_BYPASS_EN.
`default_nettype none

module reg_bank #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 64,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] rs_a,
  input  logic [$clog2(DEPTH)-1:0] rt_a,
  output logic [WIDTH-1:0]         rs,
  output logic [WIDTH-1:0]         rt,
  input  logic [$clog2(DEPTH)-1:0] rd_a,
  input  logic [WIDTH-1:0]         rd,
  input  logic                     write,
  input  logic                     rsv,
  input  logic [$clog2(DEPTH)-1:0] rsv_a,
  output logic                     rs_busy,
  output logic                     rt_busy,
  output logic                     hazard
);

  localparam int   AW = $clog2(DEPTH);
  localparam logic ZR = (ZERO_REG != 0);

  logic [WIDTH-1:0] regs [0:DEPTH-1];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  logic in_rs, in_rt, in_rd, in_rsv;
  logic wr_ok, rv_ok, rs_ok, rt_ok;
  logic [WIDTH-1:0] rs_val, rt_val;
  logic             rs_bval, rt_bval;

  // Addresses past DEPTH only exist when DEPTH is not a power of two.
  generate
    if ((2 ** AW) == DEPTH) begin : g_pow2
      assign in_rs  = 1'b1;
      assign in_rt  = 1'b1;
      assign in_rd  = 1'b1;
      assign in_rsv = 1'b1;
    end else begin : g_npow2
      localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
      assign in_rs  = ({1'b0, rs_a}  < DEPTH_W);
      assign in_rt  = ({1'b0, rt_a}  < DEPTH_W);
      assign in_rd  = ({1'b0, rd_a}  < DEPTH_W);
      assign in_rsv = ({1'b0, rsv_a} < DEPTH_W);
    end
  endgenerate

  assign wr_ok = write & in_rd  & ~(ZR && (rd_a  == '0));
  assign rv_ok = rsv   & in_rsv & ~(ZR && (rsv_a == '0));
  assign rs_ok = in_rs & ~(ZR && (rs_a == '0));
  assign rt_ok = in_rt & ~(ZR && (rt_a == '0));

  // Reserve is applied after the clear so the newer producer wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) busy_nxt[rd_a]  = 1'b0;
    if (rv_ok) busy_nxt[rsv_a] = 1'b1;
  end

`ifdef REG_BANK_BYPASS_EN
  always_comb begin
    rs_val  = (wr_ok && (rd_a == rs_a)) ? rd : regs[rs_a];
    rt_val  = (wr_ok && (rd_a == rt_a)) ? rd : regs[rt_a];
    rs_bval = busy_nxt[rs_a];
    rt_bval = busy_nxt[rt_a];
  end
`else
  always_comb begin
    rs_val  = regs[rs_a];
    rt_val  = regs[rt_a];
    rs_bval = busy[rs_a];
    rt_bval = busy[rt_a];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy    <= '0;
      rs      <= '0;
      rt      <= '0;
      rs_busy <= 1'b0;
      rt_busy <= 1'b0;
    end else begin
      if (wr_ok) regs[rd_a] <= rd;
      busy    <= busy_nxt;
      rs      <= rs_ok ? rs_val  : '0;
      rt      <= rt_ok ? rt_val  : '0;
      rs_busy <= rs_ok ? rs_bval : 1'b0;
      rt_busy <= rt_ok ? rt_bval : 1'b0;
    end
  end

  assign hazard = rs_busy | rt_busy;

endmodule

`default_nettype wire

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed and randomized checks of reg_bank against an array-based reference model.
`default_nettype none

module tb_reg_bank;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  rs_a = '0, rt_a = '0, rd_a = '0, rsv_a = '0;
  logic [31:0] rd = '0;
  logic        write = 1'b0, rsv = 1'b0;
  logic [31:0] rs, rt;
  logic        rs_busy, rt_busy, hazard;

  logic [3:0]  s_rs_a = '0, s_rt_a = '0, s_rd_a = '0, s_rsv_a = '0;
  logic [15:0] s_rd = '0;
  logic        s_write = 1'b0, s_rsv = 1'b0;
  logic [15:0] s_rs, s_rt;
  logic        s_rs_busy, s_rt_busy, s_hazard;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [64];
  bit          mbusy [64];

  always #5 clk = ~clk;

  reg_bank dut (
    .clk(clk), .rst_n(rst_n), .rs_a(rs_a), .rt_a(rt_a), .rs(rs), .rt(rt),
    .rd_a(rd_a), .rd(rd), .write(write), .rsv(rsv), .rsv_a(rsv_a),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .hazard(hazard)
  );

  reg_bank #(.WIDTH(16), .DEPTH(12), .ZERO_REG(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .rs_a(s_rs_a), .rt_a(s_rt_a), .rs(s_rs), .rt(s_rt),
    .rd_a(s_rd_a), .rd(s_rd), .write(s_write), .rsv(s_rsv), .rsv_a(s_rsv_a),
    .rs_busy(s_rs_busy), .rt_busy(s_rt_busy), .hazard(s_hazard)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      mem[i]   = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [5:0] a);
    if (a == 0) return '0;
    if (BYP && write && rd_a != 0 && rd_a == a) return rd;
    return mem[a];
  endfunction

  function automatic bit exp_busy(input logic [5:0] a);
    if (a == 0) return 1'b0;
    if (BYP) begin
      if (rsv && rsv_a == a) return 1'b1;
      if (write && rd_a == a) return 1'b0;
    end
    return mbusy[a];
  endfunction

  // One clock: predict outputs from pre-edge state, advance the model, then compare.
  task automatic cycle(input string tag);
    logic [31:0] ers, ert;
    bit          esb, etb;
    ers = exp_data(rs_a);
    ert = exp_data(rt_a);
    esb = exp_busy(rs_a);
    etb = exp_busy(rt_a);
    @(posedge clk);
    #1;
    if (write && rd_a != 0) begin
      mem[rd_a]   = rd;
      mbusy[rd_a] = 1'b0;
    end
    if (rsv && rsv_a != 0) mbusy[rsv_a] = 1'b1;
    chk({tag, ".rs"}, rs, ers);
    chk({tag, ".rt"}, rt, ert);
    chk({tag, ".rs_busy"}, {31'b0, rs_busy}, {31'b0, esb});
    chk({tag, ".rt_busy"}, {31'b0, rt_busy}, {31'b0, etb});
    chk({tag, ".hazard"}, {31'b0, hazard}, {31'b0, esb | etb});
  endtask

  task automatic idle();
    write = 1'b0;
    rsv   = 1'b0;
  endtask

  initial begin
    model_clear();
    #2 rst_n = 1'b0;
    #3;
    chk("rst.rs", rs, 32'h0);
    chk("rst.rt", rt, 32'h0);
    chk("rst.hazard", {31'b0, hazard}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Small configuration: in-range write, out-of-range write/reserve/read.
    s_write = 1'b1; s_rd_a = 4'd11; s_rd = 16'hABCD;
    @(negedge clk);
    s_rd_a = 4'd13; s_rd = 16'h7777; s_rsv = 1'b1; s_rsv_a = 4'd13;
    @(negedge clk);
    s_write = 1'b0; s_rsv = 1'b0; s_rs_a = 4'd11; s_rt_a = 4'd13;
    @(posedge clk); #1;
    chk("small.rs11", {16'b0, s_rs}, 32'h0000ABCD);
    chk("small.rt13", {16'b0, s_rt}, 32'h0);
    chk("small.busy13", {31'b0, s_rt_busy}, 32'h0);

    // Basic write/read of reg 7 on both ports.
    write = 1'b1; rd_a = 6'd7; rd = 32'hDEADBEEF;
    cycle("wr7");
    idle(); rs_a = 6'd7; rt_a = 6'd7;
    cycle("rd7");
    chk("rd7.direct", rs, 32'hDEADBEEF);

    // Asynchronous reset mid-cycle with data loaded and a write pending.
    @(negedge clk);
    write = 1'b1; rd_a = 6'd5; rd = 32'hCAFEF00D;
    rst_n = 1'b0;
    #1;
    chk("arst.rs", rs, 32'h0);
    chk("arst.rt", rt, 32'h0);
    chk("arst.busy", {30'b0, rs_busy, rt_busy}, 32'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    idle(); rs_a = 6'd5; rt_a = 6'd7;
    cycle("post_rst");
    chk("post_rst.rs5", rs, 32'h0);

    // Zero register ignores writes and reservations.
    write = 1'b1; rd_a = 6'd0; rd = 32'h1234; rsv = 1'b1; rsv_a = 6'd0;
    cycle("zero_wr");
    idle(); rs_a = 6'd0; rt_a = 6'd0;
    cycle("zero_rd");
    chk("zero.hazard", {31'b0, hazard}, 32'h0);

    // Scoreboard: reserve, clear by write, simultaneous reserve+write.
    rsv = 1'b1; rsv_a = 6'd3;
    cycle("rsv3");
    idle(); rs_a = 6'd3;
    cycle("rd3_busy");
    chk("sb.busy", {31'b0, rs_busy}, 32'h1);
    write = 1'b1; rd_a = 6'd3; rd = 32'h55;
    cycle("wr3");
    idle();
    cycle("rd3_clear");
    chk("sb.clear", {31'b0, rs_busy}, 32'h0);
    chk("sb.data", rs, 32'h55);
    write = 1'b1; rd_a = 6'd3; rd = 32'h66; rsv = 1'b1; rsv_a = 6'd3;
    cycle("rsv_wr3");
    idle();
    cycle("rd3_both");
    chk("sb.both", {31'b0, rs_busy}, 32'h1);

    // Same-edge read-after-write on reg 9.
    write = 1'b1; rd_a = 6'd9; rd = 32'h11;
    cycle("wr9a");
    rd = 32'h22; rs_a = 6'd9;
    cycle("raw9");
    chk("raw9.direct", rs, BYP ? 32'h22 : 32'h11);
    idle();
    cycle("raw9_next");
    chk("raw9.next", rs, 32'h22);

    // Randomized traffic confined to 16 addresses to force collisions.
    for (int n = 0; n < 400; n++) begin
      rs_a  = 6'($urandom_range(0, 15));
      rt_a  = 6'($urandom_range(0, 15));
      rd_a  = 6'($urandom_range(0, 15));
      rsv_a = 6'($urandom_range(0, 15));
      rd    = $urandom;
      write = 1'($urandom);
      rsv   = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
